// File: rtl/gcd_result_display.sv
// Converts each new GCD result to BCD with a sequential double-dabble engine and
// drives a 4-digit multiplexed, active-low 7-segment display with leading-zero blanking.
module gcd_result_display #(
    parameter int WIDTH        = 8,
    parameter int REFRESH_BITS = 18
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             gld,
    input  logic [WIDTH-1:0] gcd_in,
    output logic             busy,
    output logic             cnv_done,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CONV  = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    logic [1:0]              state_reg,   state_next;
    logic                    gld_q_reg;
    logic [WIDTH-1:0]        bin_sr_reg,  bin_sr_next;
    logic [15:0]             bcd_reg,     bcd_next;
    logic [CNT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [15:0]             disp_reg,    disp_next;
    logic [REFRESH_BITS-1:0] refresh_reg;

    logic        start;
    logic [15:0] bcd_adj;

    assign start = gld && !gld_q_reg;

    // Add-3 correction, one independent adder per BCD nibble.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        bin_sr_next  = bin_sr_reg;
        bcd_next     = bcd_reg;
        bit_cnt_next = bit_cnt_reg;
        disp_next    = disp_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    bin_sr_next  = gcd_in;
                    bcd_next     = 16'd0;
                    bit_cnt_next = CNT_W'(WIDTH);
                    state_next   = CONV;
                end
            end
            CONV: begin
                // {bcd, bin_sr} rotates left; bcd_adj[15] is always 0 for legal widths.
                bcd_next     = {bcd_adj[14:0], bin_sr_reg[WIDTH-1]};
                bin_sr_next  = {bin_sr_reg[WIDTH-2:0], bcd_adj[15]};
                bit_cnt_next = bit_cnt_reg - 1'b1;
                if (bit_cnt_reg == CNT_W'(1)) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                disp_next  = bcd_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg   <= IDLE;
            gld_q_reg   <= 1'b0;
            bin_sr_reg  <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            disp_reg    <= '0;
            refresh_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gld_q_reg   <= gld;
            bin_sr_reg  <= bin_sr_next;
            bcd_reg     <= bcd_next;
            bit_cnt_reg <= bit_cnt_next;
            disp_reg    <= disp_next;
            refresh_reg <= refresh_reg + 1'b1;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign cnv_done = (state_reg == LATCH);

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h7F;
        endcase
    endfunction

    logic [1:0] sel;
    logic [3:0] digit;
    logic [3:0] blank;

    assign sel = refresh_reg[REFRESH_BITS-1 -: 2];

    // A digit is blank when it and every more significant digit are zero.
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (disp_reg[15:12] == 4'd0);
        blank[2] = blank[3] && (disp_reg[11:8] == 4'd0);
        blank[1] = blank[2] && (disp_reg[7:4] == 4'd0);
    end

    always_comb begin
        digit = disp_reg[4*sel +: 4];
        an    = ~(4'b0001 << sel);
        seg   = blank[sel] ? 7'h7F : seg_of(digit);
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_gcd_result_display.sv
// Self-checking bench for gcd_result_display: table-driven conversions with a
// scoreboard queue of expected display contents, plus reset and hold sequences.
module tb_gcd_result_display;

    localparam int WIDTH = 8;
    localparam int RB    = 4;

    logic       clk = 1'b0;
    logic       clr;
    logic       gld;
    logic [7:0] gcd_in;
    logic       busy;
    logic       cnv_done;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    always #5 clk = ~clk;

    gcd_result_display #(.WIDTH(WIDTH), .REFRESH_BITS(RB)) dut (
        .clk      (clk),
        .clr      (clr),
        .gld      (gld),
        .gcd_in   (gcd_in),
        .busy     (busy),
        .cnv_done (cnv_done),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    typedef struct {
        logic [7:0]  value;
        logic [27:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t        vecs[8];
    logic [27:0] exp_q[$];
    logic [27:0] shown;
    int          errors = 0;
    int          checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'b1110: an_index = 0;
            4'b1101: an_index = 1;
            4'b1011: an_index = 2;
            4'b0111: an_index = 3;
            default: an_index = -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_disp(input string name, input logic [27:0] e);
        logic [6:0] seen[4];
        int bad_an;
        int k;
        bad_an = 0;
        for (int i = 0; i < 4; i++) seen[i] = 7'h55;
        for (int c = 0; c < 16; c++) begin
            k = an_index(an);
            if (k < 0) bad_an++;
            else seen[k] = seg;
            tick();
        end
        check($sformatf("%s an_onehot", name), bad_an, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s seg%0d", name, i), {25'd0, seen[i]}, {25'd0, e[7*i +: 7]});
    endtask

    // Waits for cnv_done after a start edge has been driven; the edge is sampled at the next posedge.
    task automatic await_done(input string name, input logic [7:0] v);
        int lat, busy_bad, old_bad, k;
        logic [27:0] e;
        lat = -1; busy_bad = 0; old_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (!busy) busy_bad++;
            if (cnv_done) begin
                lat = c;
                break;
            end
            k = an_index(an);
            if (k >= 0 && seg !== shown[7*k +: 7]) old_bad++;
        end
        check($sformatf("%s latency", name), lat, WIDTH + 1);
        check($sformatf("%s busy_during", name), busy_bad, 0);
        check($sformatf("%s old_value_held", name), old_bad, 0);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 28'h0;
        tick();
        check($sformatf("%s busy_after", name), busy, 1'b0);
        check($sformatf("%s done_single", name), cnv_done, 1'b0);
        check_disp(name, e);
        shown = e;
        $display("conv %s value=%0d latency=%0d", name, v, lat);
    endtask

    task automatic run_conv(input string name, input logic [7:0] v, input logic [27:0] e);
        gld = 1'b0;
        tick();
        tick();
        gcd_in = v;
        gld    = 1'b1;
        exp_q.push_back(e);
        await_done(name, v);
    endtask

    initial begin
        int an_bad, seg_bad, sel, n_done, n_busy;
        vecs[0] = '{8'd6,   {7'h7F, 7'h7F, 7'h7F, 7'h02}};
        vecs[1] = '{8'd255, {7'h7F, 7'h24, 7'h12, 7'h12}};
        vecs[2] = '{8'd105, {7'h7F, 7'h79, 7'h40, 7'h12}};
        vecs[3] = '{8'd0,   {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[4] = '{8'd9,   {7'h7F, 7'h7F, 7'h7F, 7'h10}};
        vecs[5] = '{8'd200, {7'h7F, 7'h24, 7'h40, 7'h40}};
        vecs[6] = '{8'd48,  {7'h7F, 7'h7F, 7'h19, 7'h00}};
        vecs[7] = '{8'd170, {7'h7F, 7'h79, 7'h78, 7'h40}};
        shown = {7'h7F, 7'h7F, 7'h7F, 7'h40};

        clr = 1'b1; gld = 1'b0; gcd_in = 8'd0;
        tick(); tick(); tick();
        check("reset an", an, 4'b1110);
        check("reset seg", seg, 7'h40);
        check("reset busy", busy, 1'b0);
        check("reset cnv_done", cnv_done, 1'b0);
        check("reset dp", dp, 1'b1);
        clr = 1'b0;

        an_bad = 0; seg_bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            sel = ((i + 1) % 16) / 4;
            if (an_index(an) != sel) an_bad++;
            if (seg !== ((sel == 0) ? 7'h40 : 7'h7F)) seg_bad++;
        end
        check("refresh an_sequence", an_bad, 0);
        check("refresh seg_blanking", seg_bad, 0);
        $display("reset refresh sequence done");

        for (int i = 0; i < 8; i++)
            run_conv($sformatf("vec%0d", i), vecs[i].value, vecs[i].segs);

        // gld stays high: no retrigger, and input changes do not reach the display.
        gcd_in = 8'd33;
        n_done = 0; n_busy = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (cnv_done) n_done++;
            if (busy) n_busy++;
        end
        check("hold no_done", n_done, 0);
        check("hold no_busy", n_busy, 0);
        check_disp("hold", shown);
        $display("hold gld high 50 cycles done_pulses=%0d", n_done);

        // Reset in the middle of a conversion, gld still high at release.
        gld = 1'b0;
        tick(); tick();
        gcd_in = 8'd77;
        gld    = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("midrst busy_before", busy, 1'b1);
        clr = 1'b1;
        #1;
        check("midrst busy", busy, 1'b0);
        check("midrst cnv_done", cnv_done, 1'b0);
        check("midrst an", an, 4'b1110);
        check("midrst seg", seg, 7'h40);
        tick(); tick();
        clr = 1'b0;
        shown = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        exp_q.push_back({7'h7F, 7'h7F, 7'h78, 7'h78});
        await_done("restart", 8'd77);

        check("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gcd_result_display.md
Name: gcd_result_display

Overview:
- Downstream stage of the GCD controller/datapath; consumes the result register and its load strobe (`gld`).
- On each new result, converts the binary GCD to 4 BCD digits with a sequential double-dabble engine.
- Drives a 4-digit multiplexed, active-low 7-segment display with leading-zero blanking.

Parameters:
- WIDTH, 8, bit width of `gcd_in`; legal range 4..13, since 13 bits is the largest width whose results all fit 4 decimal digits.
- REFRESH_BITS, 18, width of the free-running refresh counter; top 2 bits select the active digit. Benches use 4.

Ports:
- clk  input  1  system clock
- clr  input  1  asynchronous active-high reset
- gld  input  1  result-valid level from the GCD controller; held high while the result is stable
- gcd_in  input  WIDTH  binary GCD result
- busy  output  1  high while a conversion is in progress
- cnv_done  output  1  one-cycle pulse when new digits are latched to the display
- an  output  4  digit enables, active low; an[0] is the least significant digit
- seg  output  7  segments, active low; seg[0]=a … seg[6]=g
- dp  output  1  decimal point, active low; constant 1 (off)

Behaviour:
- Reset (clr=1, asynchronous):
  - state=IDLE, busy=0, cnv_done=0, gld_q=0.
  - Shift register, BCD working register, display digit register and refresh counter all cleared to 0.
  - Outputs right after reset: an=4'b1110, seg=7'b1000000 (shows "0"), dp=1.
- Start detection:
  - gld_q registers gld every cycle.
  - Conversion starts only on a rising edge (gld=1 and gld_q=0) while in IDLE.
  - A level held high does not retrigger.
  - An edge seen while in CONV is ignored; no queueing.
- FSM states: IDLE, CONV, LATCH.
  - IDLE -> CONV on start edge.
    - Load bin_sr=gcd_in, bcd=0, bit_cnt=WIDTH.
    - busy=1 from the next cycle.
  - CONV, once per cycle:
    - Each BCD nibble >=5 gets +3.
    - Then shift {bcd,bin_sr} left by 1; bit_cnt decrements.
    - When bit_cnt reaches 1 after the shift, go to LATCH.
    - Exactly WIDTH cycles are spent in CONV.
  - LATCH: disp_digits<=bcd; cnv_done=1 for this cycle only; busy=0 next cycle; go to IDLE.
  - Latency from the cycle sampling the gld edge to cnv_done high is WIDTH+1 cycles.
  - Display digits update in the cycle after cnv_done.
  - The old value stays displayed throughout CONV.
- Width rules:
  - bcd is 16 bits; the add-3 correction is combinational per nibble.
  - An input value >9999 is impossible for the legal WIDTH range; no saturation logic.
- Refresh:
  - Counter increments every cycle and wraps at 2^REFRESH_BITS.
  - sel = counter[MSB:MSB-1]; sel=k drives an[k]=0 and all others 1.
  - Counter and digit mux keep running during CONV and are unaffected by gld.
- Leading-zero blanking:
  - Digit k (k>=1) is blanked (seg=7'h7F, an still asserted) if it and all higher digits are 0.
  - Digit 0 is never blanked.
- Segment map for digits 0-9: 40,79,24,30,19,12,02,78,00,10 (hex, active low).
- Reset mid-conversion:
  - Aborts immediately; displays "0".
  - After clr release, the edge detector needs gld to go low→high again. If gld is already high at release, gld_q=0 makes it an edge, so a new conversion starts.

Test Plan:
- Reset: clr pulse, REFRESH_BITS=4 -> an=1110, seg=40, busy=0, cnv_done=0. Over the next 64 cycles an cycles through 1110,1101,1011,0111 with seg=7F on digits 1-3.
- WIDTH=8, gcd_in=8'd6, gld 0→1 -> busy high for cycles 1..9 after the edge; cnv_done pulses exactly once at cycle 9. Display shows "6" on an[0]; other digits blank.
- gcd_in=8'd255 -> digits 2,5,5. an[3] blank, an[2] seg=24, an[1] seg=12, an[0] seg=12.
- gld held high 50 cycles after a conversion -> no second cnv_done; changing gcd_in meanwhile does not change the display.
- Second result: gld low, then high with gcd_in=8'd105 -> previous value displayed until LATCH, then "105" with seg=79,40,12 on an[2..0]. Digit 1 (zero) is not blanked.
- clr asserted mid-CONV (cycle 4) with gld held high -> display "0", busy=0. After release a fresh conversion runs and cnv_done follows WIDTH+1 cycles later.
